// File: rtl/plusarg_config_loader.sv
// plusarg_config_loader
//   Replays N 32-bit plusarg words as an ordered stream of configuration
//   register writes. After reset (or a start pulse while done) it idles for
//   SETTLE cycles, then issues one valid/ready write per entry at
//   BASE_ADDR + i*STRIDE (AW bits, silent wrap), then reports done.
//
//   Optional feature macro: PLUSARG_LOADER_SKIP_DEFAULT_EN
//     When defined, an entry whose value equals its DEFAULTS word is not
//     written. It costs one cycle with wr_valid=0 and does not count.
//
// Ports
//   clock, reset_n : block clock, asynchronous active-low reset
//   values         : N packed 32-bit plusarg words, entry i = [32*i+31:32*i]
//   start          : re-run request, only acted on while done
//   wr_valid/ready : write handshake, wr_addr/wr_data held during stalls
//   busy, done     : run status (busy in settle/issue, done when finished)
//   wr_count       : writes accepted in the current run
module plusarg_config_loader #(
  parameter int              N         = 4,
  parameter int              AW        = 12,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter int              STRIDE    = 4,
  parameter int              SETTLE    = 2,
  parameter logic [32*N-1:0] DEFAULTS  = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [32*N-1:0] values,
  input  logic            start,
  output logic            wr_valid,
  input  logic            wr_ready,
  output logic [AW-1:0]   wr_addr,
  output logic [31:0]     wr_data,
  output logic            busy,
  output logic            done,
  output logic [6:0]      wr_count
);

  typedef enum logic [1:0] {S_SETTLE, S_ISSUE, S_DONE} state_t;

  localparam logic [7:0]    SETTLE_C = 8'(SETTLE);
  localparam logic [6:0]    N_C      = 7'(N);
  localparam logic [AW-1:0] STRIDE_C = AW'(STRIDE);

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [6:0]      idx_q, idx_d;
  logic            wr_valid_q, wr_valid_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [6:0]      wr_count_q, wr_count_d;

  // Entry presentation request: index and address of the entry to load.
  logic            load_en;
  logic [6:0]      load_idx;
  logic [AW-1:0]   load_addr;
  logic [31:0]     entry;
  logic            skip_hit;

`ifndef PLUSARG_LOADER_SKIP_DEFAULT_EN
  // Defaults only matter when skipping is compiled in.
  logic unused_defaults;
  assign unused_defaults = ^DEFAULTS;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    wr_count_d = wr_count_q;
    load_en    = 1'b0;
    load_idx   = idx_q;
    load_addr  = wr_addr_q;
    entry      = '0;
    skip_hit   = 1'b0;

    unique case (state_q)
      S_SETTLE: begin
        if (cnt_q == SETTLE_C) begin
          load_en   = 1'b1;
          load_idx  = '0;
          load_addr = BASE_ADDR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ISSUE: begin
        // A handshake or a skip cycle both move on to the next entry;
        // a stalled write holds everything.
        if (wr_valid_q && wr_ready) begin
          wr_count_d = wr_count_q + 7'd1;
          load_en    = 1'b1;
          load_idx   = idx_q + 7'd1;
          load_addr  = wr_addr_q + STRIDE_C;
        end else if (!wr_valid_q) begin
          load_en    = 1'b1;
          load_idx   = idx_q + 7'd1;
          load_addr  = wr_addr_q + STRIDE_C;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d    = S_SETTLE;
          cnt_d      = '0;
          idx_d      = '0;
          wr_count_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      default: state_d = S_SETTLE;
    endcase

    // Constant-index mux keeps out-of-range selects out of the netlist.
    for (int k = 0; k < N; k++) begin
      if (load_idx == 7'(k)) begin
        entry = values[32*k +: 32];
`ifdef PLUSARG_LOADER_SKIP_DEFAULT_EN
        skip_hit = (values[32*k +: 32] == DEFAULTS[32*k +: 32]);
`endif
      end
    end

    if (load_en) begin
      if (load_idx == N_C) begin
        state_d    = S_DONE;
        wr_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
      end else begin
        state_d    = S_ISSUE;
        idx_d      = load_idx;
        wr_addr_d  = load_addr;
        wr_data_d  = entry;
        wr_valid_d = !skip_hit;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_SETTLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_plusarg_config_loader.sv
// Bench for plusarg_config_loader: main instance (BASE 0x100), a wrapping
// instance (BASE 0xFF8) and a skip-configured instance share all inputs.
module tb_plusarg_config_loader;
  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            wr_ready = 1'b0;
  logic [32*N-1:0] values;

  logic        wr_valid, busy, done;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  wr_count;
  logic        w2_valid, w2_busy, w2_done;
  logic [11:0] w2_addr;
  logic [31:0] w2_data;
  logic [6:0]  w2_count;
  logic        ws_valid, ws_busy, ws_done;
  logic [11:0] ws_addr;
  logic [31:0] ws_data;
  logic [6:0]  ws_count;

  plusarg_config_loader #(.N(N), .AW(12), .BASE_ADDR(12'h100), .STRIDE(4), .SETTLE(2),
    .DEFAULTS('0)) dut (
    .clock(clock), .reset_n(reset_n), .values(values), .start(start),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .wr_count(wr_count));

  plusarg_config_loader #(.N(N), .AW(12), .BASE_ADDR(12'hFF8), .STRIDE(4), .SETTLE(2),
    .DEFAULTS('0)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .values(values), .start(start),
    .wr_valid(w2_valid), .wr_ready(wr_ready), .wr_addr(w2_addr), .wr_data(w2_data),
    .busy(w2_busy), .done(w2_done), .wr_count(w2_count));

  plusarg_config_loader #(.N(N), .AW(12), .BASE_ADDR(12'h100), .STRIDE(4), .SETTLE(2),
    .DEFAULTS({32'h0, 32'h33, 32'h0, 32'h11})) dut_skip (
    .clock(clock), .reset_n(reset_n), .values(values), .start(start),
    .wr_valid(ws_valid), .wr_ready(wr_ready), .wr_addr(ws_addr), .wr_data(ws_data),
    .busy(ws_busy), .done(ws_done), .wr_count(ws_count));

  always #5 clock = ~clock;

  typedef struct packed {logic [11:0] a; logic [31:0] d;} wr_t;
  wr_t sbq[$];
  wr_t exp_w;
  int  n_pass = 0;
  int  n_total = 0;

  task automatic set_vals();
    values = {32'h44, 32'h33, 32'h22, 32'h11};
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    sbq.push_back(w);
  endtask

  // Holds reset for two cycles, releases on a falling edge: the next rising
  // edge is cycle 1 and the following falling edge samples cycle 1 outputs.
  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    set_vals();
    reset_n = 1'b0;
    @(negedge clock);
    n_total++; if (wr_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", wr_valid); else n_pass++;
    n_total++; if (wr_addr !== 12'h0) $display("FAIL reset_addr got %0h exp 0", wr_addr); else n_pass++;
    n_total++; if (wr_data !== 32'h0) $display("FAIL reset_data got %0h exp 0", wr_data); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL reset_busy got %0h exp 1", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %0h exp 0", done); else n_pass++;
    n_total++; if (wr_count !== 7'd0) $display("FAIL reset_count got %0d exp 0", wr_count); else n_pass++;
  endtask

  task automatic test_basic();
    int first_v = -1;
    int done_c = -1;
    set_vals(); wr_ready = 1'b1; sbq.delete();
    push(12'h100, 32'h11); push(12'h104, 32'h22); push(12'h108, 32'h33); push(12'h10C, 32'h44);
    do_reset();
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clock);
      start = (c == 1);  // lands in SETTLE, must be ignored
      if (wr_valid && first_v < 0) first_v = c;
      if (wr_valid && wr_ready) begin
        n_total++;
        if (sbq.size() == 0) $display("FAIL basic_extra_write got %0h/%0h exp none", wr_addr, wr_data);
        else begin
          exp_w = sbq.pop_front();
          if ({wr_addr, wr_data} !== exp_w) $display("FAIL basic_write got %0h/%0h exp %0h/%0h", wr_addr, wr_data, exp_w.a, exp_w.d);
          else n_pass++;
        end
      end
      if (done) done_c = c;
    end
    start = 1'b0;
    n_total++; if (first_v != 3) $display("FAIL basic_first_valid got %0d exp 3", first_v); else n_pass++;
    n_total++; if (done_c != 7) $display("FAIL basic_done_cycle got %0d exp 7", done_c); else n_pass++;
    n_total++; if (wr_count !== 7'd4) $display("FAIL basic_count got %0d exp 4", wr_count); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy got %0h exp 0", busy); else n_pass++;
    n_total++; if (sbq.size() != 0) $display("FAIL basic_missing got %0d left exp 0", sbq.size()); else n_pass++;
  endtask

  task automatic test_stall();
    int done_c = -1;
    int stalls = 0;
    set_vals(); wr_ready = 1'b1; sbq.delete();
    push(12'h100, 32'h11); push(12'h104, 32'h22); push(12'h108, 32'h33); push(12'h10C, 32'h44);
    do_reset();
    for (int c = 1; c <= 30 && done_c < 0; c++) begin
      @(negedge clock);
      if (wr_valid && wr_addr == 12'h104 && stalls < 3) begin
        wr_ready = 1'b0;
        stalls++;
        if (stalls == 2) values[63:32] = 32'h99;
        n_total++; if (wr_data !== 32'h22) $display("FAIL stall_hold_data got %0h exp 22", wr_data); else n_pass++;
      end else wr_ready = 1'b1;
      if (wr_valid && wr_ready) begin
        n_total++;
        if (sbq.size() == 0) $display("FAIL stall_extra_write got %0h/%0h exp none", wr_addr, wr_data);
        else begin
          exp_w = sbq.pop_front();
          if ({wr_addr, wr_data} !== exp_w) $display("FAIL stall_write got %0h/%0h exp %0h/%0h", wr_addr, wr_data, exp_w.a, exp_w.d);
          else n_pass++;
        end
      end
      if (done) done_c = c;
    end
    wr_ready = 1'b1;
    n_total++; if (done_c != 10) $display("FAIL stall_done_cycle got %0d exp 10", done_c); else n_pass++;
    n_total++; if (wr_count !== 7'd4) $display("FAIL stall_count got %0d exp 4", wr_count); else n_pass++;
  endtask

  // Runs from the DONE state left by the previous test.
  task automatic test_restart();
    int done_c = -1;
    set_vals(); values[31:0] = 32'h55; wr_ready = 1'b1; sbq.delete();
    push(12'h100, 32'h55); push(12'h104, 32'h22); push(12'h108, 32'h33); push(12'h10C, 32'h44);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL restart_busy got %0h exp 1", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL restart_done got %0h exp 0", done); else n_pass++;
    n_total++; if (wr_count !== 7'd0) $display("FAIL restart_count_clr got %0d exp 0", wr_count); else n_pass++;
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clock);
      if (wr_valid && wr_ready) begin
        n_total++;
        if (sbq.size() == 0) $display("FAIL restart_extra_write got %0h/%0h exp none", wr_addr, wr_data);
        else begin
          exp_w = sbq.pop_front();
          if ({wr_addr, wr_data} !== exp_w) $display("FAIL restart_write got %0h/%0h exp %0h/%0h", wr_addr, wr_data, exp_w.a, exp_w.d);
          else n_pass++;
        end
      end
      if (done) done_c = c;
    end
    n_total++; if (done_c != 7) $display("FAIL restart_done_cycle got %0d exp 7", done_c); else n_pass++;
    n_total++; if (wr_count !== 7'd4) $display("FAIL restart_count got %0d exp 4", wr_count); else n_pass++;
  endtask

  task automatic test_midreset();
    int done_c = -1;
    bit hit = 1'b0;
    set_vals(); wr_ready = 1'b1; sbq.delete();
    push(12'h100, 32'h11); push(12'h104, 32'h22); push(12'h108, 32'h33); push(12'h10C, 32'h44);
    do_reset();
    for (int c = 1; c <= 20 && !hit; c++) begin
      @(negedge clock);
      if (wr_valid && wr_addr == 12'h108) begin
        hit = 1'b1;
        reset_n = 1'b0;
        #1;
        n_total++; if (wr_valid !== 1'b0) $display("FAIL midreset_valid got %0h exp 0", wr_valid); else n_pass++;
        n_total++; if (wr_count !== 7'd0) $display("FAIL midreset_count got %0d exp 0", wr_count); else n_pass++;
      end else if (wr_valid && wr_ready) begin
        n_total++;
        if (sbq.size() == 0) $display("FAIL midreset_extra_write got %0h/%0h exp none", wr_addr, wr_data);
        else begin
          exp_w = sbq.pop_front();
          if ({wr_addr, wr_data} !== exp_w) $display("FAIL midreset_write got %0h/%0h exp %0h/%0h", wr_addr, wr_data, exp_w.a, exp_w.d);
          else n_pass++;
        end
      end
    end
    n_total++; if (!hit) $display("FAIL midreset_no_entry2 got none exp entry 2"); else n_pass++;
    sbq.delete();
    push(12'h100, 32'h11); push(12'h104, 32'h22); push(12'h108, 32'h33); push(12'h10C, 32'h44);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clock);
      if (wr_valid && wr_ready) begin
        n_total++;
        if (sbq.size() == 0) $display("FAIL midreset_replay_extra got %0h/%0h exp none", wr_addr, wr_data);
        else begin
          exp_w = sbq.pop_front();
          if ({wr_addr, wr_data} !== exp_w) $display("FAIL midreset_replay got %0h/%0h exp %0h/%0h", wr_addr, wr_data, exp_w.a, exp_w.d);
          else n_pass++;
        end
      end
      if (done) done_c = c;
    end
    n_total++; if (done_c != 7) $display("FAIL midreset_done_cycle got %0d exp 7", done_c); else n_pass++;
    n_total++; if (wr_count !== 7'd4) $display("FAIL midreset_replay_count got %0d exp 4", wr_count); else n_pass++;
  endtask

  task automatic test_wrap();
    int done_c = -1;
    set_vals(); wr_ready = 1'b1; sbq.delete();
    push(12'hFF8, 32'h11); push(12'hFFC, 32'h22); push(12'h000, 32'h33); push(12'h004, 32'h44);
    do_reset();
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clock);
      if (w2_valid && wr_ready) begin
        n_total++;
        if (sbq.size() == 0) $display("FAIL wrap_extra_write got %0h/%0h exp none", w2_addr, w2_data);
        else begin
          exp_w = sbq.pop_front();
          if ({w2_addr, w2_data} !== exp_w) $display("FAIL wrap_write got %0h/%0h exp %0h/%0h", w2_addr, w2_data, exp_w.a, exp_w.d);
          else n_pass++;
        end
      end
      if (w2_done) done_c = c;
    end
    n_total++; if (done_c != 7) $display("FAIL wrap_done_cycle got %0d exp 7", done_c); else n_pass++;
    n_total++; if (w2_count !== 7'd4) $display("FAIL wrap_count got %0d exp 4", w2_count); else n_pass++;
  endtask

`ifdef PLUSARG_LOADER_SKIP_DEFAULT_EN
  task automatic test_skip();
    int done_c = -1;
    int first_v = -1;
    set_vals(); wr_ready = 1'b1; sbq.delete();
    push(12'h104, 32'h22); push(12'h10C, 32'h44);
    do_reset();
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clock);
      if (ws_valid && first_v < 0) first_v = c;
      if (ws_valid && wr_ready) begin
        n_total++;
        if (sbq.size() == 0) $display("FAIL skip_extra_write got %0h/%0h exp none", ws_addr, ws_data);
        else begin
          exp_w = sbq.pop_front();
          if ({ws_addr, ws_data} !== exp_w) $display("FAIL skip_write got %0h/%0h exp %0h/%0h", ws_addr, ws_data, exp_w.a, exp_w.d);
          else n_pass++;
        end
      end
      if (ws_done) done_c = c;
    end
    n_total++; if (first_v != 4) $display("FAIL skip_first_valid got %0d exp 4", first_v); else n_pass++;
    n_total++; if (done_c != 7) $display("FAIL skip_done_cycle got %0d exp 7", done_c); else n_pass++;
    n_total++; if (ws_count !== 7'd2) $display("FAIL skip_count got %0d exp 2", ws_count); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_restart();
    test_midreset();
    test_wrap();
`ifdef PLUSARG_LOADER_SKIP_DEFAULT_EN
    test_skip();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
